// File: rtl/decoder_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : decoder_pkg
//  Description : Shared constants for the decoder_seq block.
//                - Widths of the code, one-hot and counter paths.
//                - Default hold/gap lengths.
//                - State encoding of the IDLE/HOLD/GAP sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
package decoder_pkg;

    localparam int c_CODE_W          = 2;
    localparam int c_DEC_W           = 4;
    localparam int c_CNT_W           = 8;

    localparam int c_HOLD_CYCLES_DEF = 4;
    localparam int c_GAP_CYCLES_DEF  = 1;

    typedef logic [c_CNT_W-1:0] cnt_t;
    typedef logic [1:0]         state_t;

    localparam state_t c_ST_IDLE = 2'd0;
    localparam state_t c_ST_HOLD = 2'd1;
    localparam state_t c_ST_GAP  = 2'd2;

endpackage
`default_nettype wire

// File: rtl/decoder_2to4.sv
`default_nettype none
// ============================================================================
//  Module      : decoder_2to4
//  Description : Purely combinational 2-to-4 one-hot decoder.
//                Output is 1 shifted left by the input code.
//  Ports       : i_code    [1:0]  binary code
//                o_onehot  [3:0]  one-hot decode of i_code
//  Revision    : 1.0 - initial release
// ============================================================================
module decoder_2to4
    import decoder_pkg::*;
(
    input  logic [c_CODE_W-1:0] i_code,
    output logic [c_DEC_W-1:0]  o_onehot
);

    localparam logic [c_DEC_W-1:0] c_ONE = {{(c_DEC_W-1){1'b0}}, 1'b1};

    always_comb begin
        o_onehot = c_ONE << i_code;
    end

endmodule
`default_nettype wire

// File: rtl/decoder_seq.sv
`default_nettype none
// ============================================================================
//  Module      : decoder_seq
//  Description : Accepts a 2-bit code, drives its registered one-hot decode
//                for HOLD_CYCLES cycles, pulses done as the output clears,
//                then stays busy for GAP_CYCLES idle cycles before the next
//                code can be accepted.
//  Ports       : clk        clock, all state on the rising edge
//                rst        synchronous active-high reset
//                code_in    [1:0] code, sampled only on an accept
//                valid_in   code_in is valid
//                ready_out  block is idle and can accept this cycle
//                dec_out    [3:0] registered one-hot decode or zero
//                busy       inverse of ready_out (HOLD or GAP)
//                done       one-cycle pulse marking the end of a hold
//  Revision    : 1.0 - initial release
// ============================================================================
module decoder_seq
    import decoder_pkg::*;
#(
    parameter int HOLD_CYCLES = c_HOLD_CYCLES_DEF,  // 1..255
    parameter int GAP_CYCLES  = c_GAP_CYCLES_DEF    // 0..255
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [c_CODE_W-1:0] code_in,
    input  logic                valid_in,
    output logic                ready_out,
    output logic [c_DEC_W-1:0]  dec_out,
    output logic                busy,
    output logic                done
);

    // Counter reload values; the counter counts down to zero so a load of
    // N-1 yields exactly N cycles in the state.
    localparam cnt_t c_HOLD_LOAD = cnt_t'(HOLD_CYCLES - 1);
    localparam cnt_t c_GAP_LOAD  = (GAP_CYCLES > 0) ? cnt_t'(GAP_CYCLES - 1) : '0;
    localparam bit   c_HAS_GAP   = (GAP_CYCLES > 0);
    localparam cnt_t c_CNT_ONE   = cnt_t'(1);

    state_t               r_state;
    cnt_t                 r_cnt;
    logic [c_DEC_W-1:0]   r_dec;
    logic                 r_done;

    logic [c_DEC_W-1:0]   w_onehot;
    logic                 w_accept;

    decoder_2to4 u_decoder_2to4 (
        .i_code   (code_in),
        .o_onehot (w_onehot)
    );

    assign ready_out = (r_state == c_ST_IDLE);
    assign busy      = ~ready_out;
    assign w_accept  = valid_in & ready_out;
    assign dec_out   = r_dec;
    assign done      = r_done;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_ST_IDLE;
            r_cnt   <= '0;
            r_dec   <= '0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                c_ST_IDLE: begin
                    r_cnt <= '0;
                    if (w_accept) begin
                        r_dec   <= w_onehot;
                        r_cnt   <= c_HOLD_LOAD;
                        r_state <= c_ST_HOLD;
                    end
                end

                c_ST_HOLD: begin
                    if (r_cnt == '0) begin
                        // Last hold cycle: clear output and flag completion.
                        r_dec  <= '0;
                        r_done <= 1'b1;
                        if (c_HAS_GAP) begin
                            r_state <= c_ST_GAP;
                            r_cnt   <= c_GAP_LOAD;
                        end else begin
                            // No gap: idle (and ready) in the done cycle.
                            r_state <= c_ST_IDLE;
                            r_cnt   <= '0;
                        end
                    end else begin
                        r_cnt <= r_cnt - c_CNT_ONE;
                    end
                end

                c_ST_GAP: begin
                    if (r_cnt == '0) begin
                        r_state <= c_ST_IDLE;
                    end else begin
                        r_cnt <= r_cnt - c_CNT_ONE;
                    end
                end

                default: begin
                    r_state <= c_ST_IDLE;
                    r_cnt   <= '0;
                    r_dec   <= '0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_decoder_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_decoder_seq
//  Description : Self-checking bench for decoder_seq. Instance A uses the
//                default parameters, instance B uses HOLD_CYCLES=1 and
//                GAP_CYCLES=0. Accepted codes are pushed to a per-instance
//                scoreboard and popped when the decode appears; a small
//                transaction model tracks hold/gap timing, done and ready.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_decoder_seq;

    typedef struct {
        bit         armed;
        bit         p_rst;
        bit         p_acc;
        int         hold_left;
        int         gap_left;
        logic [3:0] cur;
    } mdl_t;

    localparam logic [3:0] c_ONE = 4'b0001;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_total = 0;
    int n_bad   = 0;

    // Instance A: defaults
    logic       r_a_rst, r_a_valid;
    logic [1:0] r_a_code;
    logic       w_a_ready, w_a_busy, w_a_done;
    logic [3:0] w_a_dec;

    // Instance B: HOLD_CYCLES=1, GAP_CYCLES=0
    logic       r_b_rst, r_b_valid;
    logic [1:0] r_b_code;
    logic       w_b_ready, w_b_busy, w_b_done;
    logic [3:0] w_b_dec;

    decoder_seq u_dut_a (
        .clk       (clk),
        .rst       (r_a_rst),
        .code_in   (r_a_code),
        .valid_in  (r_a_valid),
        .ready_out (w_a_ready),
        .dec_out   (w_a_dec),
        .busy      (w_a_busy),
        .done      (w_a_done)
    );

    decoder_seq #(
        .HOLD_CYCLES (1),
        .GAP_CYCLES  (0)
    ) u_dut_b (
        .clk       (clk),
        .rst       (r_b_rst),
        .code_in   (r_b_code),
        .valid_in  (r_b_valid),
        .ready_out (w_b_ready),
        .dec_out   (w_b_dec),
        .busy      (w_b_busy),
        .done      (w_b_done)
    );

    mdl_t       r_ma;
    mdl_t       r_mb;
    logic [3:0] q_a [$];
    logic [3:0] q_b [$];

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // One cycle of the reference model, evaluated at the falling edge.
    // p_rst/p_acc describe what happened at the rising edge just passed.
    task automatic mon_step(
        input  string      tag,
        input  int         hold,
        input  int         gap,
        inout  mdl_t       m,
        input  logic [3:0] exp,
        input  logic       rst_i,
        input  logic       valid_i,
        input  logic [3:0] dec,
        input  logic       rdy,
        input  logic       bsy,
        input  logic       dn,
        output logic       acc_next
    );
        bit exp_ready;
        acc_next = 1'b0;
        if (m.p_rst) m.armed = 1'b1;
        if (m.armed) begin
            if (m.p_rst) begin
                m.hold_left = 0;
                m.gap_left  = 0;
                m.cur       = '0;
                chk_eq({tag, ".rst_dec"},  dec, 0);
                chk_eq({tag, ".rst_done"}, dn,  0);
            end else begin
                if (m.gap_left > 0) m.gap_left--;
                if (m.p_acc) begin
                    chk_eq({tag, ".dec_new"},  dec, exp);
                    chk_eq({tag, ".done_new"}, dn,  0);
                    m.cur       = exp;
                    m.hold_left = hold - 1;
                end else if (m.hold_left > 0) begin
                    chk_eq({tag, ".dec_hold"},  dec, m.cur);
                    chk_eq({tag, ".done_hold"}, dn,  0);
                    m.hold_left--;
                end else if (m.cur != 4'b0000) begin
                    chk_eq({tag, ".dec_end"},  dec, 0);
                    chk_eq({tag, ".done_end"}, dn,  1);
                    m.cur      = '0;
                    m.gap_left = gap;
                end else begin
                    chk_eq({tag, ".dec_idle"},  dec, 0);
                    chk_eq({tag, ".done_idle"}, dn,  0);
                end
            end
            exp_ready = (m.cur == 4'b0000) && (m.gap_left == 0);
            chk_eq({tag, ".ready"}, rdy, exp_ready);
            chk_eq({tag, ".busy"},  bsy, !exp_ready);
            acc_next = !rst_i && valid_i && exp_ready;
        end
        m.p_rst = rst_i;
        m.p_acc = acc_next;
    endtask

    always @(negedge clk) begin
        logic [3:0] exp;
        logic       acc;
        exp = '0;
        if (r_ma.p_acc) begin
            if (q_a.size() > 0) exp = q_a.pop_front();
            else chk_eq("A.sb_empty", q_a.size(), 1);
        end
        mon_step("A", 4, 1, r_ma, exp, r_a_rst, r_a_valid,
                 w_a_dec, w_a_ready, w_a_busy, w_a_done, acc);
        if (acc) q_a.push_back(c_ONE << r_a_code);
    end

    always @(negedge clk) begin
        logic [3:0] exp;
        logic       acc;
        exp = '0;
        if (r_mb.p_acc) begin
            if (q_b.size() > 0) exp = q_b.pop_front();
            else chk_eq("B.sb_empty", q_b.size(), 1);
        end
        mon_step("B", 1, 0, r_mb, exp, r_b_rst, r_b_valid,
                 w_b_dec, w_b_ready, w_b_busy, w_b_done, acc);
        if (acc) q_b.push_back(c_ONE << r_b_code);
    end

    // Offer a code to instance A and wait (bounded) for its accept edge.
    // Returns 2 time units after the accepting rising edge.
    task automatic send_a(input logic [1:0] c);
        bit ok;
        ok        = 1'b0;
        r_a_code  = c;
        r_a_valid = 1'b1;
        for (int i = 0; i < 32; i++) begin
            @(posedge clk);
            if (r_ma.p_acc) begin
                ok = 1'b1;
                break;
            end
        end
        #2;
        r_a_valid = 1'b0;
        chk_eq("A.accept_timeout", ok, 1);
    endtask

    initial begin
        r_ma = '{armed: 1'b0, p_rst: 1'b0, p_acc: 1'b0, hold_left: 0, gap_left: 0, cur: 4'b0000};
        r_mb = '{armed: 1'b0, p_rst: 1'b0, p_acc: 1'b0, hold_left: 0, gap_left: 0, cur: 4'b0000};

        // Reset with valid held high on both instances: nothing may be accepted.
        r_a_rst   = 1'b1;
        r_a_valid = 1'b1;
        r_a_code  = 2'd2;
        r_b_rst   = 1'b1;
        r_b_valid = 1'b1;
        r_b_code  = 2'd1;
        repeat (3) @(posedge clk);
        #2;
        r_a_rst   = 1'b0;
        r_a_valid = 1'b0;
        r_b_rst   = 1'b0;   // B now free-runs with valid=1, code=1

        repeat (2) @(posedge clk);
        #2;

        // Decode sweep, back-to-back as ready allows.
        for (int c = 0; c < 4; c++) begin
            send_a(2'(c));
        end

        // Code 3 offered during the hold of code 2 must wait for ready.
        send_a(2'd2);
        send_a(2'd3);
        repeat (8) @(posedge clk);
        #2;

        // Reset in the 2nd hold cycle of code 3: abort, no done pulse.
        send_a(2'd3);
        @(posedge clk);
        #2;
        r_a_rst = 1'b1;
        @(posedge clk);
        #2;
        r_a_rst = 1'b0;
        repeat (8) @(posedge clk);
        #2;

        r_b_valid = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        #1;
        chk_eq("A.sb_left", q_a.size(), 0);
        chk_eq("B.sb_left", q_b.size(), 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
